if_fetch_unit: RTL



---
 rtl/fetch_pkg.sv | 20 ++
 rtl/if_id_buf.sv | 56 +++++
 rtl/if_fetch_unit.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared state encoding and constants for the instruction-fetch stage
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2,
        DRAIN = 2'd3
    } fetch_state_e;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [31:0] PC_INC           = 32'd4;
    localparam logic [31:0] PC_ALIGN_MASK    = 32'hFFFF_FFFC;

    function automatic logic [31:0] align_pc(input logic [31:0] pc);
        return pc & PC_ALIGN_MASK;
    endfunction

endpackage

// File: rtl/if_id_buf.sv
// rtl/if_id_buf.sv - single-entry IF/ID buffer with load, flush and ready handshake
// Ports: clk, rst (sync, active-high); load/load_instr/load_pc write the entry;
//        flush empties it; id_ready consumes it; buf_free says a load may land
//        next edge; if_valid/if_instr/if_pc/if_pc_plus4 face decode.
module if_id_buf #(
    parameter logic [31:0] NOP_INSTR = fetch_pkg::NOP_INSTR
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        flush,
    input  logic [31:0] load_instr,
    input  logic [31:0] load_pc,
    input  logic        id_ready,
    output logic        buf_free,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    output logic [31:0] if_pc_plus4
);
    import fetch_pkg::*;

    logic        valid_q;
    logic [31:0] instr_q;
    logic [31:0] pc_q;
    logic [31:0] pc4_q;

    // The slot is free for a new entry when it is empty or is being consumed now.
    assign buf_free = !valid_q || id_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            instr_q <= NOP_INSTR;
            pc_q    <= 32'h0000_0000;
            pc4_q   <= PC_INC;
        end else if (flush) begin
            valid_q <= 1'b0;
            instr_q <= NOP_INSTR;
        end else if (load) begin
            valid_q <= 1'b1;
            instr_q <= load_instr;
            pc_q    <= load_pc;
            pc4_q   <= load_pc + PC_INC;
        end else if (valid_q && id_ready) begin
            // Consumed without a refill: only the valid flag drops, payload is kept.
            valid_q <= 1'b0;
        end
    end

    assign if_valid    = valid_q;
    assign if_instr    = valid_q ? instr_q : NOP_INSTR;
    assign if_pc       = pc_q;
    assign if_pc_plus4 = pc4_q;

endmodule

// File: rtl/if_fetch_unit.sv
// rtl/if_fetch_unit.sv - instruction-fetch stage: PC, instruction-memory port, IF/ID buffer
// Ports: clk, rst (sync, active-high); mem_cen_I/mem_wen_I/mem_addr_I/mem_rdata_I/
//        mem_stall_I instruction memory; redirect_valid/redirect_pc from execute;
//        id_ready from decode; if_valid/if_instr/if_pc/if_pc_plus4 to decode.
// Option IF_PERF_CNT_EN adds perf_fetch_cnt and perf_stall_cnt outputs.
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC  = fetch_pkg::RESET_PC_DEFAULT,
    parameter logic [31:0] NOP_INSTR = fetch_pkg::NOP_INSTR
) (
    input  logic        clk,
    input  logic        rst,
    output logic        mem_cen_I,
    output logic        mem_wen_I,
    output logic [31:0] mem_addr_I,
    input  logic [31:0] mem_rdata_I,
    input  logic        mem_stall_I,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        id_ready,
`ifdef IF_PERF_CNT_EN
    output logic [31:0] perf_fetch_cnt,
    output logic [31:0] perf_stall_cnt,
`endif
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    output logic [31:0] if_pc_plus4
);
    import fetch_pkg::*;

    fetch_state_e state;
    fetch_state_e state_nxt;
    logic [31:0]  pc;
    logic [31:0]  pc_nxt;
    logic [31:0]  drain_addr;
    logic         buf_free;
    logic         buf_load;
    logic         req_done;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            pc         <= RESET_PC;
            drain_addr <= RESET_PC;
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
            // While fetching, remember the in-flight address so a redirect that
            // lands on a stalled request can keep presenting it during DRAIN.
            if (state == FETCH) begin
                drain_addr <= pc;
            end
        end
    end

    always_comb begin
        mem_cen_I  = 1'b0;
        mem_addr_I = pc;
        state_nxt  = state;
        case (state)
            IDLE: begin
                state_nxt = FETCH;
            end
            FETCH: begin
                // Issue only if the response can land in the buffer next edge.
                mem_cen_I = buf_free;
                if (!buf_free) begin
                    state_nxt = HOLD;
                end
            end
            HOLD: begin
                if (id_ready) begin
                    state_nxt = FETCH;
                end
            end
            DRAIN: begin
                mem_cen_I  = 1'b1;
                mem_addr_I = drain_addr;
                if (!mem_stall_I) begin
                    state_nxt = FETCH;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
        // A redirect wins over every state; a stalled request must still be
        // seen through before the new target can be fetched.
        if (redirect_valid) begin
            state_nxt = (mem_cen_I && mem_stall_I) ? DRAIN : FETCH;
        end
    end

    assign mem_wen_I = 1'b0;
    assign req_done  = mem_cen_I && !mem_stall_I;
    assign buf_load  = (state == FETCH) && req_done && !redirect_valid;

    always_comb begin
        pc_nxt = pc;
        if (redirect_valid) begin
            pc_nxt = align_pc(redirect_pc);
        end else if (buf_load) begin
            pc_nxt = pc + PC_INC;
        end
    end

    if_id_buf #(
        .NOP_INSTR (NOP_INSTR)
    ) u_if_id_buf (
        .clk         (clk),
        .rst         (rst),
        .load        (buf_load),
        .flush       (redirect_valid),
        .load_instr  (mem_rdata_I),
        .load_pc     (pc),
        .id_ready    (id_ready),
        .buf_free    (buf_free),
        .if_valid    (if_valid),
        .if_instr    (if_instr),
        .if_pc       (if_pc),
        .if_pc_plus4 (if_pc_plus4)
    );

`ifdef IF_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_fetch_cnt <= 32'd0;
            perf_stall_cnt <= 32'd0;
        end else begin
            if (buf_load) begin
                perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
            end
            if (mem_cen_I && mem_stall_I) begin
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
            end
        end
    end
`endif

endmodule
